fib_seq_master: RTL and testbench
=================================

// Module: fib_seq_master
// PURPOSE
//  Requester/checker end of the fib valid/ready protocol: issues indices 0..max_n to a fib engine,
//  accepts each result, compares it to an internally tracked Fibonacci sequence.
//  Sits in front of the fib core as a self-test sequencer; reports done/pass/error count to the host.
// PARAMETERS
//  INPUT_WIDTH     8     width of request index (matches fib INPUT_WIDTH)
//  OUTPUT_WIDTH    32    width of result/expected value (matches fib OUTPUT_WIDTH)
//  ERR_WIDTH       8     width of saturating mismatch counter
//  TIMEOUT_CYCLES  1024  response watchdog limit (used only with FIB_SEQ_TIMEOUT_EN)
// PORTS
//  clk        in   1             clock, all state on rising edge
//  rst        in   1             asynchronous, active-high reset
//  start      in   1             pulse: begin a run (sampled only in IDLE)
//  max_n      in   INPUT_WIDTH   last index to request; latched on accepted start
//  req_n      out  INPUT_WIDTH   index to fib engine (fib fib_in)
//  req_vld    out  1             request valid (fib vld_in)
//  req_rdy    in   1             engine ready for request (fib rdy_in)
//  rsp_data   in   OUTPUT_WIDTH  engine result (fib fib_out)
//  rsp_vld    in   1             result valid (fib vld_out)
//  rsp_rdy    out  1             result accepted (fib rdy_out)
//  busy       out  1             high in SEND/WAIT
//  done       out  1             one-cycle pulse when run finishes
//  pass       out  1             1 if last run had zero mismatches (and no timeout); held until next start
//  err_count  out  ERR_WIDTH     mismatches in current/last run, saturates at all-ones
//  timeout    out  1             watchdog fired in last run (0 when feature compiled out)
// BEHAVIOUR
//  - Reset: state=IDLE; req_n=0, req_vld=0, rsp_rdy=0, busy=0, done=0, pass=0, err_count=0, timeout=0.
//  - Transfer rule: beat moves at posedge where vld&&rdy; req_vld/req_n held stable until accepted.
//  - One outstanding request max; no new request until the previous response is accepted.
//  - FSM: IDLE -start-> SEND (latch max_n, n=0, exp_a=0, exp_b=1, err_count=0, pass=0, timeout=0).
//    SEND: req_vld=1, req_n=n; on req_rdy -> WAIT. WAIT: rsp_rdy=1 (registered, asserted on WAIT entry);
//    on rsp_vld: compare rsp_data==exp_a, err_count+=mismatch (sat); exp_a<=exp_b, exp_b<=exp_a+exp_b;
//    if n==max_n -> DONE else n<=n+1 -> SEND. DONE: done=1 one cycle, pass=(err_count_final==0), -> IDLE.
//  - Latency: start at edge k -> req_vld=1 from k+1; rsp accepted at edge m -> next req_vld=1 from m+1.
//  - Arithmetic: exp_a/exp_b are OUTPUT_WIDTH, wrap mod 2^OUTPUT_WIDTH (matches engine truncation).
//  - Termination compares n==max_n before increment: max_n=2^INPUT_WIDTH-1 must not wrap/loop forever.
//  - max_n=0: exactly one request (n=0), expected 0.
//  - start while busy ignored; rsp_vld in IDLE/SEND ignored (rsp_rdy=0); req_rdy outside SEND ignored.
//  - Mismatch detected on final beat is included in pass evaluation (same-cycle update).
//  - rst mid-run: asynchronous return to IDLE, req_vld/rsp_rdy drop immediately, results discarded.
// CONFIGURATION
//  FIB_SEQ_TIMEOUT_EN defined: cycle counter runs in WAIT, clears on rsp accept; reaching
//    TIMEOUT_CYCLES -> timeout=1, pass=0, DONE (done pulse), rsp_rdy dropped.
//  Not defined: no counter, WAIT indefinitely, timeout tied 0.
// TESTING
//  1 start, max_n=10, ideal engine -> 11 reqs n=0..10, rsp 0,1,1,2,3,5,8,13,21,34,55; done, pass=1, err=0.
//  2 max_n=0 -> single req n=0, rsp 0 -> done pass=1; start pulsed during run -> ignored, req count unchanged.
//  3 engine returns 56 for n=10 -> err_count=1, pass=0 at done; two bad beats -> err_count=2.
//  4 max_n=48, 32-bit engine -> F(47)=2971215073, F(48)=512559680 (wrapped) accepted, pass=1.
//  5 random req_rdy/rsp_vld stalls (0-5 cycles) -> req_n/req_vld stable while stalled, results unchanged.
//  6 rst asserted in WAIT at n=5 -> req_vld=rsp_rdy=busy=0 immediately; new start restarts from n=0.

Source files
------------

// File: rtl/fib_seq_master.sv
// fib_seq_master: self-test sequencer that requests Fibonacci indices 0..max_n and checks each result
// Ports: clk, rst (async, active-high); start_i/max_n_i begin a run; req_n_o/req_vld_o/req_rdy_i request channel;
//   rsp_data_i/rsp_vld_i/rsp_rdy_o response channel; busy_o, done_o (pulse), pass_o, err_count_o, timeout_o status.
// Optional macro FIB_SEQ_TIMEOUT_EN adds a response watchdog of TIMEOUT_CYCLES cycles.
module fib_seq_master #(
  parameter int INPUT_WIDTH    = 8,
  parameter int OUTPUT_WIDTH   = 32,
  parameter int ERR_WIDTH      = 8,
  parameter int TIMEOUT_CYCLES = 1024
) (
  input  logic                    clk,
  input  logic                    rst,
  input  logic                    start_i,
  input  logic [INPUT_WIDTH-1:0]  max_n_i,
  output logic [INPUT_WIDTH-1:0]  req_n_o,
  output logic                    req_vld_o,
  input  logic                    req_rdy_i,
  input  logic [OUTPUT_WIDTH-1:0] rsp_data_i,
  input  logic                    rsp_vld_i,
  output logic                    rsp_rdy_o,
  output logic                    busy_o,
  output logic                    done_o,
  output logic                    pass_o,
  output logic [ERR_WIDTH-1:0]    err_count_o,
  output logic                    timeout_o
);
  typedef enum logic [1:0] {IDLE, SEND, WAIT, DONE} state_t;
  state_t                  state_q, state_d;
  logic [INPUT_WIDTH-1:0]  n_q, n_d, max_q, max_d;
  logic [OUTPUT_WIDTH-1:0] exp_a_q, exp_a_d, exp_b_q, exp_b_d;
  logic [ERR_WIDTH-1:0]    err_q, err_d, err_nx;
  logic                    pass_q, pass_d, to_q, to_d, acc, miss;
`ifdef FIB_SEQ_TIMEOUT_EN
  localparam int CW = $clog2(TIMEOUT_CYCLES + 1);
  logic [CW-1:0] cnt_q, cnt_d;
  logic          expire;
  assign cnt_d  = (state_q == WAIT && !rsp_vld_i) ? cnt_q + CW'(1) : '0;
  assign expire = state_q == WAIT && !rsp_vld_i && cnt_q == CW'(TIMEOUT_CYCLES - 1);
  always_ff @(posedge clk or posedge rst)
    if (rst) cnt_q <= '0;
    else     cnt_q <= cnt_d;
`endif
  assign acc    = state_q == WAIT && rsp_vld_i;
  assign miss   = rsp_data_i != exp_a_q;
  // saturating add so a long bad run never wraps back to a clean count
  assign err_nx = err_q + ERR_WIDTH'(miss && (err_q != '1));
  always_comb begin
    state_d = state_q;
    n_d     = n_q;
    max_d   = max_q;
    exp_a_d = exp_a_q;
    exp_b_d = exp_b_q;
    err_d   = err_q;
    pass_d  = pass_q;
    to_d    = to_q;
    case (state_q)
      IDLE: if (start_i) begin
        state_d = SEND;
        max_d   = max_n_i;
        n_d     = '0;
        exp_a_d = '0;
        exp_b_d = OUTPUT_WIDTH'(1);
        err_d   = '0;
        pass_d  = 1'b0;
        to_d    = 1'b0;
      end
      SEND: state_d = req_rdy_i ? WAIT : SEND;
      WAIT: if (acc) begin
        err_d   = err_nx;
        exp_a_d = exp_b_q;
        exp_b_d = exp_a_q + exp_b_q;
        // compare before incrementing so max_n = all-ones terminates
        if (n_q == max_q) begin
          state_d = DONE;
          pass_d  = err_nx == '0;
        end else begin
          state_d = SEND;
          n_d     = n_q + INPUT_WIDTH'(1);
        end
      end
`ifdef FIB_SEQ_TIMEOUT_EN
      else if (expire) begin
        state_d = DONE;
        to_d    = 1'b1;
        pass_d  = 1'b0;
      end
`endif
      default: state_d = IDLE;
    endcase
  end
  always_ff @(posedge clk or posedge rst)
    if (rst) begin
      state_q <= IDLE;
      n_q     <= '0;
      max_q   <= '0;
      exp_a_q <= '0;
      exp_b_q <= '0;
      err_q   <= '0;
      pass_q  <= 1'b0;
      to_q    <= 1'b0;
    end else begin
      state_q <= state_d;
      n_q     <= n_d;
      max_q   <= max_d;
      exp_a_q <= exp_a_d;
      exp_b_q <= exp_b_d;
      err_q   <= err_d;
      pass_q  <= pass_d;
      to_q    <= to_d;
    end
  assign req_n_o     = n_q;
  assign req_vld_o   = state_q == SEND;
  assign rsp_rdy_o   = state_q == WAIT;
  assign busy_o      = state_q == SEND || state_q == WAIT;
  assign done_o      = state_q == DONE;
  assign pass_o      = pass_q;
  assign err_count_o = err_q;
  assign timeout_o   = to_q;
endmodule

// File: tb/tb_fib_seq_master.sv
// tb_fib_seq_master: directed bench driving fib_seq_master with a behavioural fib engine
module tb_fib_seq_master;
  localparam int IW = 8, OW = 32, EW = 8;
  logic          clk = 0, rst = 1, start_i = 0, req_rdy_i = 0, rsp_vld_i = 0;
  logic [IW-1:0] max_n_i = '0;
  logic [OW-1:0] rsp_data_i = '0;
  logic [IW-1:0] req_n_o;
  logic          req_vld_o, rsp_rdy_o, busy_o, done_o, pass_o, timeout_o;
  logic [EW-1:0] err_count_o;
  int nvec = 0, nerr = 0;
  always #5 clk = ~clk;
  fib_seq_master #(.INPUT_WIDTH(IW), .OUTPUT_WIDTH(OW), .ERR_WIDTH(EW), .TIMEOUT_CYCLES(1024)) dut (
    .clk(clk), .rst(rst), .start_i(start_i), .max_n_i(max_n_i), .req_n_o(req_n_o),
    .req_vld_o(req_vld_o), .req_rdy_i(req_rdy_i), .rsp_data_i(rsp_data_i), .rsp_vld_i(rsp_vld_i),
    .rsp_rdy_o(rsp_rdy_o), .busy_o(busy_o), .done_o(done_o), .pass_o(pass_o),
    .err_count_o(err_count_o), .timeout_o(timeout_o));
  function automatic logic [OW-1:0] fib(input int n);
    logic [OW-1:0] a = 0, b = 1, t;
    for (int i = 0; i < n; i++) begin
      t = a + b;
      a = b;
      b = t;
    end
    return a;
  endfunction
  task automatic run(input int mx, input bit stall, input int bad0, input int bad1, input int abort_n,
                     input bit pulse, output int reqs, output logic p, output logic [EW-1:0] e);
    int cyc, d;
    logic [IW-1:0] n;
    reqs = 0; p = 0; e = 0; cyc = 0;
    @(negedge clk); max_n_i = IW'(mx); start_i = 1;
    @(negedge clk); start_i = 0; max_n_i = '0;
    nvec++;
    if (req_vld_o !== 1'b1 || busy_o !== 1'b1) begin
      nerr++; $display("FAIL start_latency req_vld=%b busy=%b want 1 1", req_vld_o, busy_o);
    end
    forever begin
      while (!req_vld_o && !done_o && cyc < 5000) begin @(negedge clk); cyc++; end
      if (done_o || cyc >= 5000) break;
      n = req_n_o;
      nvec++;
      if (n !== IW'(reqs)) begin nerr++; $display("FAIL req_n got %0d want %0d", n, reqs); end
      d = stall ? $urandom_range(5, 0) : 0;
      rsp_vld_i = stall; rsp_data_i = 32'hDEAD_BEEF;
      repeat (d) begin
        @(negedge clk); cyc++; nvec++;
        if (req_vld_o !== 1'b1 || req_n_o !== n) begin
          nerr++; $display("FAIL stall_hold req_vld=%b req_n=%0d want 1 %0d", req_vld_o, req_n_o, n);
        end
      end
      rsp_vld_i = 0;
      req_rdy_i = 1; @(negedge clk); req_rdy_i = 0; reqs++; cyc++;
      nvec++;
      if (req_vld_o !== 1'b0 || rsp_rdy_o !== 1'b1) begin
        nerr++; $display("FAIL wait_entry req_vld=%b rsp_rdy=%b want 0 1", req_vld_o, rsp_rdy_o);
      end
      if (int'(n) == abort_n) begin
        #1 rst = 1; #1;
        nvec++;
        if (req_vld_o !== 1'b0 || rsp_rdy_o !== 1'b0 || busy_o !== 1'b0) begin
          nerr++; $display("FAIL async_rst req_vld=%b rsp_rdy=%b busy=%b want 0 0 0", req_vld_o, rsp_rdy_o, busy_o);
        end
        @(negedge clk); rst = 0;
        return;
      end
      if (pulse) begin start_i = 1; max_n_i = 8'd9; @(negedge clk); start_i = 0; max_n_i = '0; cyc++; end
      d = stall ? $urandom_range(5, 0) : 0;
      repeat (d) begin req_rdy_i = 1; @(negedge clk); cyc++; end
      req_rdy_i = 0;
      rsp_vld_i = 1;
      rsp_data_i = fib(int'(n)) + ((int'(n) == bad0 || int'(n) == bad1) ? 32'd1 : 32'd0);
      @(negedge clk); rsp_vld_i = 0; rsp_data_i = '0; cyc++;
      nvec++;
      if (!done_o && req_vld_o !== 1'b1) begin
        nerr++; $display("FAIL next_req_latency req_vld=%b want 1", req_vld_o);
      end
    end
    if (cyc >= 5000) begin
      nvec++; nerr++; $display("FAIL run_budget cycles=%0d want done before 5000", cyc);
      return;
    end
    p = pass_o; e = err_count_o;
    @(negedge clk);
    nvec++;
    if (done_o !== 1'b0 || busy_o !== 1'b0 || pass_o !== p) begin
      nerr++; $display("FAIL done_pulse done=%b busy=%b pass=%b want 0 0 %b", done_o, busy_o, pass_o, p);
    end
  endtask
  task automatic test_reset;
    repeat (2) @(negedge clk);
    nvec++;
    if (req_vld_o !== 0 || rsp_rdy_o !== 0 || busy_o !== 0 || done_o !== 0) begin
      nerr++; $display("FAIL reset_ctrl vld=%b rdy=%b busy=%b done=%b want 0000", req_vld_o, rsp_rdy_o, busy_o, done_o);
    end
    nvec++;
    if (req_n_o !== 0 || pass_o !== 0 || err_count_o !== 0 || timeout_o !== 0) begin
      nerr++; $display("FAIL reset_status n=%0d pass=%b err=%0d to=%b want 0 0 0 0", req_n_o, pass_o, err_count_o, timeout_o);
    end
    rst = 0;
    @(negedge clk);
    nvec++;
    if (busy_o !== 0) begin nerr++; $display("FAIL idle_after_reset busy=%b want 0", busy_o); end
  endtask
  task automatic check_run(input string name, input int reqs, input logic p, input logic [EW-1:0] e,
                           input int wreqs, input logic wp, input logic [EW-1:0] we);
    nvec++;
    if (reqs !== wreqs || p !== wp || e !== we || timeout_o !== 1'b0) begin
      nerr++;
      $display("FAIL %s reqs=%0d pass=%b err=%0d to=%b want %0d %b %0d 0", name, reqs, p, e, timeout_o, wreqs, wp, we);
    end
  endtask
  task automatic test_basic;
    int r; logic p; logic [EW-1:0] e;
    run(10, 0, -1, -1, -1, 0, r, p, e);
    check_run("basic_n10", r, p, e, 11, 1'b1, 8'd0);
  endtask
  task automatic test_max0;
    int r; logic p; logic [EW-1:0] e;
    run(0, 0, -1, -1, -1, 1, r, p, e);
    check_run("max0_start_ignored", r, p, e, 1, 1'b1, 8'd0);
    repeat (3) @(negedge clk);
    nvec++;
    if (busy_o !== 1'b0) begin nerr++; $display("FAIL max0_no_restart busy=%b want 0", busy_o); end
  endtask
  task automatic test_mismatch;
    int r; logic p; logic [EW-1:0] e;
    run(10, 0, 10, -1, -1, 0, r, p, e);
    check_run("bad_last_beat", r, p, e, 11, 1'b0, 8'd1);
    run(10, 0, 3, 7, -1, 0, r, p, e);
    check_run("two_bad_beats", r, p, e, 11, 1'b0, 8'd2);
  endtask
  task automatic test_wrap;
    int r; logic p; logic [EW-1:0] e;
    nvec++;
    if (fib(48) !== 32'd512559680 || fib(47) !== 32'd2971215073) begin
      nerr++; $display("FAIL model_fib47_48 got %0d %0d want 2971215073 512559680", fib(47), fib(48));
    end
    run(48, 0, -1, -1, -1, 0, r, p, e);
    check_run("wrap_n48", r, p, e, 49, 1'b1, 8'd0);
    run(255, 0, -1, -1, -1, 0, r, p, e);
    check_run("max_index_255", r, p, e, 256, 1'b1, 8'd0);
  endtask
  task automatic test_stall;
    int r; logic p; logic [EW-1:0] e;
    run(10, 1, -1, -1, -1, 0, r, p, e);
    check_run("random_stalls", r, p, e, 11, 1'b1, 8'd0);
    run(6, 1, 4, -1, -1, 0, r, p, e);
    check_run("stalls_with_error", r, p, e, 7, 1'b0, 8'd1);
  endtask
  task automatic test_reset_mid;
    int r; logic p; logic [EW-1:0] e;
    run(10, 0, -1, -1, 5, 0, r, p, e);
    nvec++;
    if (r !== 6 || pass_o !== 1'b0 || err_count_o !== 0) begin
      nerr++; $display("FAIL abort_at_5 reqs=%0d pass=%b err=%0d want 6 0 0", r, pass_o, err_count_o);
    end
    run(3, 0, -1, -1, -1, 0, r, p, e);
    check_run("restart_after_rst", r, p, e, 4, 1'b1, 8'd0);
  endtask
  initial begin
    test_reset;
    test_basic;
    test_max0;
    test_mismatch;
    test_wrap;
    test_stall;
    test_reset_mid;
    $display("== %0d vectors applied, %0d miscompares ==", nvec, nerr);
    $finish;
  end
endmodule
